// File: rtl/mem_io_responder_if.sv
// CPU byte bus and UART byte streams as seen by the memory/I-O responder.
// slave = responder side, master = CPU/UART side.
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        rdy_o;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        prog_stop;

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
        output cpu_din, rdy_o, rx_ready, tx_data, tx_valid, prog_stop
    );

    modport master (
        output cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
        input  cpu_din, rdy_o, rx_ready, tx_data, tx_valid, prog_stop
    );
endinterface

// File: rtl/mem_io_responder.sv
// 128 KB RAM + UART FIFOs/stop port/cycle counter (macro IO_CYCLE_COUNTER_EN) at 0x30000.
// Reads 1 cycle, writes 0 cycles; rdy_o drops while an rx-empty read or tx-full write is presented.
module mem_io_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_empty,
    output logic             o_full
);
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [DEPTH_LOG:0] r_wr_ptr;
    logic [DEPTH_LOG:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[DEPTH_LOG] != r_rd_ptr[DEPTH_LOG]) &&
                        (r_wr_ptr[DEPTH_LOG-1:0] == r_rd_ptr[DEPTH_LOG-1:0]);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG-1:0]];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= i_push_dat;
    end
endmodule

module mem_io_responder #(
    parameter int ADDR_WIDTH     = 17,
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    mem_io_responder_if.slave  bus
);
    logic       w_io, w_ram, w_io_00, w_io_04, w_io_cnt;
    logic       w_stall_rx, w_stall_tx, w_acc;
    logic       w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
    logic [7:0] w_rx_head;
    logic       w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0] w_tx_head, w_tx_push_dat;
    logic [7:0] w_io_rdata, w_cnt_byte;
    logic       w_unused_a;

    logic [7:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] r_ram_q;
    logic [7:0] r_io_q;
    logic       r_rd_ram;
    logic       r_prog_stop;

    assign w_unused_a = &{1'b0, bus.cpu_a[31:18]};

    assign w_io     = (bus.cpu_a[17:16] == 2'b11);
    assign w_ram    = !bus.cpu_a[17];
    assign w_io_00  = w_io && (bus.cpu_a[15:0] == 16'h0000);
    assign w_io_04  = w_io && (bus.cpu_a[15:0] == 16'h0004);
    assign w_io_cnt = w_io && (bus.cpu_a[15:2] == 14'h0001);

    // Dropped zero bytes and ignored stop writes still stall on a full tx FIFO.
    assign w_stall_rx = w_io_00 && !bus.cpu_wr && w_rx_empty;
    assign w_stall_tx = (w_io_00 || w_io_04) && bus.cpu_wr && w_tx_full;
    assign bus.rdy_o  = !rst_in && !w_stall_rx && !w_stall_tx;
    assign w_acc      = bus.rdy_o;

    assign bus.rx_ready = !rst_in && !w_rx_full;
    assign w_rx_push    = bus.rx_valid && bus.rx_ready;
    assign w_rx_pop     = w_acc && !bus.cpu_wr && w_io_00;

    assign bus.tx_valid = !rst_in && !w_tx_empty;
    assign bus.tx_data  = bus.tx_valid ? w_tx_head : 8'h00;
    assign w_tx_pop     = bus.tx_valid && bus.tx_ready;
    assign w_tx_push    = w_acc && bus.cpu_wr &&
                          ((w_io_00 && (bus.cpu_dout != 8'h00)) || (w_io_04 && !r_prog_stop));
    assign w_tx_push_dat = w_io_00 ? bus.cpu_dout : 8'h00;

    mem_io_fifo #(.WIDTH(8), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_push     (w_rx_push),
        .i_push_dat (bus.rx_data),
        .i_pop      (w_rx_pop),
        .o_head_dat (w_rx_head),
        .o_empty    (w_rx_empty),
        .o_full     (w_rx_full)
    );

    mem_io_fifo #(.WIDTH(8), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_push     (w_tx_push),
        .i_push_dat (w_tx_push_dat),
        .i_pop      (w_tx_pop),
        .o_head_dat (w_tx_head),
        .o_empty    (w_tx_empty),
        .o_full     (w_tx_full)
    );

`ifdef IO_CYCLE_COUNTER_EN
    logic [31:0] r_cnt;
    logic [31:0] r_snap;

    // Byte 0 comes from the live counter; the rest from the snapshot taken with it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt  <= 32'h0;
            r_snap <= 32'h0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_acc && !bus.cpu_wr && w_io_04) r_snap <= r_cnt;
        end
    end

    always_comb begin
        w_cnt_byte = 8'h00;
        case (bus.cpu_a[1:0])
            2'd0: w_cnt_byte = r_cnt[7:0];
            2'd1: w_cnt_byte = r_snap[15:8];
            2'd2: w_cnt_byte = r_snap[23:16];
            2'd3: w_cnt_byte = r_snap[31:24];
            default: w_cnt_byte = 8'h00;
        endcase
    end
`else
    assign w_cnt_byte = 8'h00;
`endif

    always_comb begin
        w_io_rdata = 8'h00;
        if (w_io_00)       w_io_rdata = w_rx_head;
        else if (w_io_cnt) w_io_rdata = w_cnt_byte;
    end

    // RAM kept out of reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk_in) begin
        if (w_acc && w_ram) begin
            if (bus.cpu_wr) r_mem[bus.cpu_a[ADDR_WIDTH-1:0]] <= bus.cpu_dout;
            else            r_ram_q <= r_mem[bus.cpu_a[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_io_q      <= 8'h00;
            r_rd_ram    <= 1'b0;
            r_prog_stop <= 1'b0;
        end else begin
            if (w_acc && !bus.cpu_wr) begin
                r_rd_ram <= w_ram;
                if (!w_ram) r_io_q <= w_io_rdata;
            end
            if (w_acc && bus.cpu_wr && w_io_04) r_prog_stop <= 1'b1;
        end
    end

    assign bus.cpu_din   = r_rd_ram ? r_ram_q : r_io_q;
    assign bus.prog_stop = r_prog_stop;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read data and tx bytes checked by a monitor.
// Stimulus drives at posedge+1, monitor samples at negedge.
module tb_mem_io_responder;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    mem_io_responder_if bus();

    mem_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH_LOG(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  rdq[$];
    logic [7:0]  txq[$];
    logic        mon_en = 1'b0;
    logic        pend   = 1'b0;
    logic [7:0]  mon_exp;
    logic [31:0] tb_cyc = 32'h0;
    logic [31:0] base;

    always @(posedge clk_in) tb_cyc <= rst_in ? 32'h0 : tb_cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read data one cycle after an accepted flagged read; tx bytes on each handshake.
    always @(negedge clk_in) begin
        if (pend) begin
            if (rdq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", bus.cpu_din);
            end else begin
                mon_exp = rdq.pop_front();
                check("rd_data", {24'h0, bus.cpu_din}, {24'h0, mon_exp});
            end
        end
        pend = !rst_in && mon_en && bus.rdy_o && !bus.cpu_wr;
        if (!rst_in && bus.tx_valid && bus.tx_ready) begin
            if (txq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", bus.tx_data);
            end else begin
                mon_exp = txq.pop_front();
                check("tx_data", {24'h0, bus.tx_data}, {24'h0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic idle();
        bus.cpu_a = 32'h0002_0000; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00; mon_en = 1'b0;
    endtask

    task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d,
                          input logic chk, input logic [7:0] exp);
        bit ok = 1'b0;
        bus.cpu_a = a; bus.cpu_wr = wr; bus.cpu_dout = d; mon_en = chk && !wr;
        if (chk && !wr) rdq.push_back(exp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (bus.rdy_o) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL access_timeout: addr 0x%0h rdy_o stuck at 0 expected 1", a);
            if (chk && !wr) void'(rdq.pop_back());
            mon_en = 1'b0;
        end
        tick();
        idle();
    endtask

    task automatic drain_tx();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 50 && bus.tx_valid; i++) tick();
        @(negedge clk_in);
        check("tx_drained_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("tx_drained_queue", txq.size(), 32'h0);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        idle();
        bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk_in);
        check("rst_cpu_din",   {24'h0, bus.cpu_din}, 32'h0);
        check("rst_rdy_o",     {31'h0, bus.rdy_o}, 32'h0);
        check("rst_rx_ready",  {31'h0, bus.rx_ready}, 32'h0);
        check("rst_tx_valid",  {31'h0, bus.tx_valid}, 32'h0);
        check("rst_prog_stop", {31'h0, bus.prog_stop}, 32'h0);
        tick();
        rst_in = 1'b0;

        // RAM and unmapped region
        access(32'h0000_1234, 1'b1, 8'hA5, 1'b0, 8'h00);
        access(32'h0000_1234, 1'b0, 8'h00, 1'b1, 8'hA5);
        access(32'h0000_0000, 1'b1, 8'h3C, 1'b0, 8'h00);
        access(32'h0001_FFFF, 1'b1, 8'h5A, 1'b0, 8'h00);
        access(32'h0000_0000, 1'b0, 8'h00, 1'b1, 8'h3C);
        access(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h5A);
        access(32'h0002_1234, 1'b1, 8'h77, 1'b0, 8'h00);
        access(32'h0002_1234, 1'b0, 8'h00, 1'b1, 8'h00);
        access(32'h0000_1234, 1'b0, 8'h00, 1'b1, 8'hA5);
        access(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);

        // rx read stalls on empty, no bypass on the push cycle
        bus.cpu_a = 32'h0003_0000; bus.cpu_wr = 1'b0; mon_en = 1'b1; rdq.push_back(8'h41);
        @(negedge clk_in); check("rx_empty_stall", {31'h0, bus.rdy_o}, 32'h0);
        tick(); bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
        @(negedge clk_in); check("rx_push_no_bypass", {31'h0, bus.rdy_o}, 32'h0);
        tick(); bus.rx_valid = 1'b0;
        @(negedge clk_in); check("rx_rdy_after_push", {31'h0, bus.rdy_o}, 32'h1);
        tick(); idle();
        bus.cpu_a = 32'h0003_0000;
        @(negedge clk_in); check("rx_empty_again", {31'h0, bus.rdy_o}, 32'h0);
        tick(); idle();

        // rx fill to full, then drain across pointer wrap
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin bus.rx_data = 8'h80 + 8'(i); tick(); end
        bus.rx_valid = 1'b0;
        @(negedge clk_in); check("rx_full_ready", {31'h0, bus.rx_ready}, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) access(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h80 + 8'(i));
        @(negedge clk_in); check("rx_ready_after_drain", {31'h0, bus.rx_ready}, 32'h1);
        tick();

        // tx: 'H', '\0', 'i'
        bus.tx_ready = 1'b1;
        txq.push_back(8'h48); access(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00);
        access(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00);
        txq.push_back(8'h69); access(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00);
        drain_tx();

        // tx full: 9th write stalls, even through a same-cycle pop
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txq.push_back(8'h11 + 8'(i));
            access(32'h0003_0000, 1'b1, 8'h11 + 8'(i), 1'b0, 8'h00);
        end
        txq.push_back(8'h19);
        bus.cpu_a = 32'h0003_0000; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h19;
        @(negedge clk_in); check("tx_full_stall", {31'h0, bus.rdy_o}, 32'h0);
        tick(); bus.tx_ready = 1'b1;
        @(negedge clk_in); check("tx_full_pop_stall", {31'h0, bus.rdy_o}, 32'h0);
        tick(); bus.tx_ready = 1'b0;
        @(negedge clk_in); check("tx_write_resumes", {31'h0, bus.rdy_o}, 32'h1);
        tick(); idle();
        drain_tx();

        // cycle counter bytes and snapshot
        repeat (256) tick();
`ifdef IO_CYCLE_COUNTER_EN
        base = tb_cyc;
`else
        base = 32'h0;
`endif
        access(32'h0003_0004, 1'b0, 8'h00, 1'b1, base[7:0]);
        access(32'h0003_0005, 1'b0, 8'h00, 1'b1, base[15:8]);
        access(32'h0003_0006, 1'b0, 8'h00, 1'b1, base[23:16]);
        access(32'h0003_0007, 1'b0, 8'h00, 1'b1, base[31:24]);
        repeat (300) tick();
        access(32'h0003_0005, 1'b0, 8'h00, 1'b1, base[15:8]);

        // stop port: one 0x00 queued, second write ignored
        bus.tx_ready = 1'b0;
        @(negedge clk_in); check("stop_before", {31'h0, bus.prog_stop}, 32'h0);
        tick();
        txq.push_back(8'h00);
        access(32'h0003_0004, 1'b1, 8'hFF, 1'b0, 8'h00);
        @(negedge clk_in);
        check("stop_set", {31'h0, bus.prog_stop}, 32'h1);
        check("stop_tx_valid", {31'h0, bus.tx_valid}, 32'h1);
        tick();
        access(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00);
        drain_tx();

        // reset mid-operation
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b1; bus.rx_data = 8'h55; tick(); bus.rx_valid = 1'b0;
        access(32'h0003_0000, 1'b1, 8'h66, 1'b0, 8'h00);
        access(32'h0000_1234, 1'b0, 8'h00, 1'b1, 8'hA5);
        tick();
        rst_in = 1'b1;
        tick();
        @(negedge clk_in);
        check("mid_rst_cpu_din",   {24'h0, bus.cpu_din}, 32'h0);
        check("mid_rst_rdy_o",     {31'h0, bus.rdy_o}, 32'h0);
        check("mid_rst_rx_ready",  {31'h0, bus.rx_ready}, 32'h0);
        check("mid_rst_tx_valid",  {31'h0, bus.tx_valid}, 32'h0);
        check("mid_rst_tx_data",   {24'h0, bus.tx_data}, 32'h0);
        check("mid_rst_prog_stop", {31'h0, bus.prog_stop}, 32'h0);
        tick();
        rst_in = 1'b0;
        @(negedge clk_in); check("post_rst_tx_empty", {31'h0, bus.tx_valid}, 32'h0);
        tick();
        bus.cpu_a = 32'h0003_0000;
        @(negedge clk_in); check("post_rst_rx_empty", {31'h0, bus.rdy_o}, 32'h0);
        tick(); idle();
        access(32'h0000_1234, 1'b0, 8'h00, 1'b1, 8'hA5);

        repeat (3) tick();
        check("rd_queue_empty", rdq.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
